// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline: carries decoder EXE/MEM/WB bundles through the
// ID/EX, EX/MEM and MEM/WB registers with bubble insertion and retire/flush stats.
module ctrl_pipe #(
  parameter int CNT_W  = 16,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        exe_in,
  input  logic [5:0]        mem_in,
  input  logic [1:0]        wb_in,
  input  logic              valid_in,
  input  logic              flush,
  input  logic              stall,
  output logic [3:0]        alu_op,
  output logic              imm_sel,
  output logic              mux1_sel,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [3:0]        br_cond,
  output logic              wb_sel,
  output logic              reg_wrt,
  output logic [CNT_W-1:0]  instret,
  output logic [FCNT_W-1:0] flush_cnt,
  output logic              illegal
);

  function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
    return (&v) ? v : v + {{(FCNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [5:0]        r_exe_p0;
  logic [5:0]        r_mem_p0;
  logic [1:0]        r_wb_p0;
  logic              r_vld_p0;
  logic [5:0]        r_mem_p1;
  logic [1:0]        r_wb_p1;
  logic              r_vld_p1;
  logic [1:0]        r_wb_p2;
  logic              r_vld_p2;
  logic [CNT_W-1:0]  r_instret;
  logic [FCNT_W-1:0] r_flush_cnt;
  logic              r_illegal;

  logic       w_bad_bundle;
  logic       w_live;
  logic       w_accept;
  logic [5:0] w_exe_clean;

  assign w_bad_bundle = mem_in[5] & mem_in[4];
  // A slot that survives flush/stall and carries a real instruction.
  assign w_live       = valid_in & ~flush & ~stall;
  assign w_accept     = w_live & ~w_bad_bundle;
  // Stores leave the mux1 select undefined; pin it low so it never carries X.
  assign w_exe_clean  = {exe_in[5], exe_in[4] & ~mem_in[4], exe_in[3:0]};

  // ---- ID/EX stage (p0) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exe_p0 <= '0;
      r_mem_p0 <= '0;
      r_wb_p0  <= '0;
      r_vld_p0 <= 1'b0;
    end else if (w_accept) begin
      r_exe_p0 <= w_exe_clean;
      r_mem_p0 <= mem_in;
      r_wb_p0  <= wb_in;
      r_vld_p0 <= 1'b1;
    end else begin
      r_exe_p0 <= '0;
      r_mem_p0 <= '0;
      r_wb_p0  <= '0;
      r_vld_p0 <= 1'b0;
    end
  end

  // ---- EX/MEM stage (p1) and MEM/WB stage (p2): never stall ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_p1 <= '0;
      r_wb_p1  <= '0;
      r_vld_p1 <= 1'b0;
      r_wb_p2  <= '0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_mem_p1 <= r_mem_p0;
      r_wb_p1  <= r_wb_p0;
      r_vld_p1 <= r_vld_p0;
      r_wb_p2  <= r_wb_p1;
      r_vld_p2 <= r_vld_p1;
    end
  end

  // ---- statistics ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret   <= '0;
      r_flush_cnt <= '0;
      r_illegal   <= 1'b0;
    end else begin
      if (r_vld_p2)
        r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
      if (flush && valid_in)
        r_flush_cnt <= sat_inc(r_flush_cnt);
      if (w_live && w_bad_bundle)
        r_illegal <= 1'b1;
    end
  end

  assign alu_op    = r_exe_p0[3:0];
  assign imm_sel   = r_exe_p0[5];
  assign mux1_sel  = r_exe_p0[4];
  assign mem_rd    = r_mem_p1[5];
  assign mem_wr    = r_mem_p1[4];
  assign br_cond   = r_mem_p1[3:0];
  assign wb_sel    = r_wb_p2[1];
  assign reg_wrt   = r_wb_p2[0] & r_vld_p2;
  assign instret   = r_instret;
  assign flush_cnt = r_flush_cnt;
  assign illegal   = r_illegal;

endmodule
